// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body: headings, FSM states and board size.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_e;

  localparam int unsigned BOARD_X_MAX = 159;
  localparam int unsigned BOARD_Y_MAX = 119;

  function automatic dir_e opposite(input dir_e d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_body_control_if.sv
// Control, pixel-query and status signals between the game logic and the snake body.
interface snake_body_control_if #(
  parameter int unsigned X_WIDTH = 8,
  parameter int unsigned Y_WIDTH = 7,
  parameter int unsigned LEN_W   = 6
);
  logic               MOVE_TICK;
  logic               START;
  logic [1:0]         DIR_IN;
  logic               GROW;
  logic [X_WIDTH-1:0] PIXEL_X;
  logic [Y_WIDTH-1:0] PIXEL_Y;
  logic               PIXEL_IS_SNAKE;
  logic               PIXEL_IS_HEAD;
  logic [X_WIDTH-1:0] HEAD_X;
  logic [Y_WIDTH-1:0] HEAD_Y;
  logic [LEN_W-1:0]   LENGTH;
  logic               RUNNING;
  logic               DEAD;

  modport master (
    output MOVE_TICK, START, DIR_IN, GROW, PIXEL_X, PIXEL_Y,
    input  PIXEL_IS_SNAKE, PIXEL_IS_HEAD, HEAD_X, HEAD_Y, LENGTH, RUNNING, DEAD
  );

  modport slave (
    input  MOVE_TICK, START, DIR_IN, GROW, PIXEL_X, PIXEL_Y,
    output PIXEL_IS_SNAKE, PIXEL_IS_HEAD, HEAD_X, HEAD_Y, LENGTH, RUNNING, DEAD
  );
endinterface

// File: rtl/snake_hit_detect.sv
// Compares one cell against the first `count` segments; bit i set when segment i matches.
module snake_hit_detect #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned X_WIDTH = 8,
  parameter int unsigned Y_WIDTH = 7,
  parameter int unsigned LEN_W   = 6
) (
  input  logic [X_WIDTH-1:0]              x,
  input  logic [Y_WIDTH-1:0]              y,
  input  logic [MAX_LEN-1:0][X_WIDTH-1:0] seg_x,
  input  logic [MAX_LEN-1:0][Y_WIDTH-1:0] seg_y,
  input  logic [LEN_W-1:0]                count,
  output logic [MAX_LEN-1:0]              hit_vec
);

  always_comb begin
    hit_vec = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      hit_vec[i] = (LEN_W'(i) < count) && (seg_x[i] == x) && (seg_y[i] == y);
    end
  end

endmodule

// File: rtl/snake_body_control.sv
// Snake body register array: moves on MOVE_TICK, wraps at the board edge, grows,
// detects self-collision and answers registered per-pixel queries.
module snake_body_control
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned INIT_LEN = 4,
  parameter int unsigned X_WIDTH  = 8,
  parameter int unsigned Y_WIDTH  = 7,
  parameter int unsigned X_MAX    = BOARD_X_MAX,
  parameter int unsigned Y_MAX    = BOARD_Y_MAX,
  parameter int unsigned START_X  = 80,
  parameter int unsigned START_Y  = 60
) (
  input  logic                 CLK,
  input  logic                 RESET,
  snake_body_control_if.slave  bus
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;

  state_e                          state_q, state_d;
  dir_e                            heading_q, heading_d, move_dir_s, dir_req_s;
  logic [LEN_W-1:0]                length_q, length_d, col_count_s;
  logic                            grow_pending_q, grow_pending_d, grow_eff_s;
  logic [MAX_LEN-1:0][X_WIDTH-1:0] seg_x_q, seg_x_d, init_x_s;
  logic [MAX_LEN-1:0][Y_WIDTH-1:0] seg_y_q, seg_y_d, init_y_s;
  logic [X_WIDTH-1:0]              new_x_s;
  logic [Y_WIDTH-1:0]              new_y_s;
  logic [MAX_LEN-1:0]              col_vec_s, pix_vec_s;
  logic                            pix_snake_q, pix_snake_d, pix_head_q, pix_head_d;

  always_comb begin
    init_x_s = {(MAX_LEN*X_WIDTH){1'b0}};
    init_y_s = {(MAX_LEN*Y_WIDTH){1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      init_y_s[i] = Y_WIDTH'(START_Y);
      if (i < INIT_LEN) init_x_s[i] = X_WIDTH'(START_X - i);
      else              init_x_s[i] = X_WIDTH'(0);
    end
  end

  assign dir_req_s  = dir_e'(bus.DIR_IN);
  assign move_dir_s = (dir_req_s == opposite(heading_q)) ? heading_q : dir_req_s;

  // One step of the head in the accepted heading, wrapping at the board edges.
  always_comb begin
    new_x_s = seg_x_q[0];
    new_y_s = seg_y_q[0];
    case (move_dir_s)
      DIR_UP:    new_y_s = (seg_y_q[0] == Y_WIDTH'(0))     ? Y_WIDTH'(Y_MAX) : seg_y_q[0] - Y_WIDTH'(1);
      DIR_DOWN:  new_y_s = (seg_y_q[0] == Y_WIDTH'(Y_MAX)) ? Y_WIDTH'(0)     : seg_y_q[0] + Y_WIDTH'(1);
      DIR_LEFT:  new_x_s = (seg_x_q[0] == X_WIDTH'(0))     ? X_WIDTH'(X_MAX) : seg_x_q[0] - X_WIDTH'(1);
      DIR_RIGHT: new_x_s = (seg_x_q[0] == X_WIDTH'(X_MAX)) ? X_WIDTH'(0)     : seg_x_q[0] + X_WIDTH'(1);
      default:   new_x_s = seg_x_q[0];
    endcase
  end

  // A saturated grow is a plain move, so the tail cell is free to be entered.
  assign grow_eff_s  = (grow_pending_q | bus.GROW) && (length_q < LEN_W'(MAX_LEN));
  assign col_count_s = grow_eff_s ? length_q : length_q - LEN_W'(1);

  snake_hit_detect #(.MAX_LEN(MAX_LEN), .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .LEN_W(LEN_W)) u_col_hit (
    .x(new_x_s), .y(new_y_s), .seg_x(seg_x_q), .seg_y(seg_y_q), .count(col_count_s), .hit_vec(col_vec_s)
  );

  snake_hit_detect #(.MAX_LEN(MAX_LEN), .X_WIDTH(X_WIDTH), .Y_WIDTH(Y_WIDTH), .LEN_W(LEN_W)) u_pix_hit (
    .x(bus.PIXEL_X), .y(bus.PIXEL_Y), .seg_x(seg_x_q), .seg_y(seg_y_q), .count(length_q), .hit_vec(pix_vec_s)
  );

  always_comb begin
    state_d        = state_q;
    heading_d      = heading_q;
    length_d       = length_q;
    grow_pending_d = grow_pending_q;
    seg_x_d        = seg_x_q;
    seg_y_d        = seg_y_q;
    pix_snake_d    = |pix_vec_s;
    pix_head_d     = pix_vec_s[0];
    case (state_q)
      ST_IDLE: begin
        if (bus.START) state_d = ST_RUN;
        else           state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (bus.MOVE_TICK) begin
          heading_d = move_dir_s;
          if (|col_vec_s) begin
            state_d = ST_DEAD;
          end else begin
            seg_x_d        = {seg_x_q[MAX_LEN-2:0], new_x_s};
            seg_y_d        = {seg_y_q[MAX_LEN-2:0], new_y_s};
            length_d       = grow_eff_s ? length_q + LEN_W'(1) : length_q;
            grow_pending_d = 1'b0;
          end
        end else if (bus.GROW) begin
          grow_pending_d = 1'b1;
        end else begin
          grow_pending_d = grow_pending_q;
        end
      end
      ST_DEAD: begin
        if (bus.START) begin
          state_d        = ST_RUN;
          heading_d      = DIR_RIGHT;
          length_d       = LEN_W'(INIT_LEN);
          grow_pending_d = 1'b0;
          seg_x_d        = init_x_s;
          seg_y_d        = init_y_s;
        end else begin
          state_d = ST_DEAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      heading_q      <= DIR_RIGHT;
      length_q       <= LEN_W'(INIT_LEN);
      grow_pending_q <= 1'b0;
      seg_x_q        <= init_x_s;
      seg_y_q        <= init_y_s;
      pix_snake_q    <= 1'b0;
      pix_head_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      heading_q      <= heading_d;
      length_q       <= length_d;
      grow_pending_q <= grow_pending_d;
      seg_x_q        <= seg_x_d;
      seg_y_q        <= seg_y_d;
      pix_snake_q    <= pix_snake_d;
      pix_head_q     <= pix_head_d;
    end
  end

  assign bus.HEAD_X         = seg_x_q[0];
  assign bus.HEAD_Y         = seg_y_q[0];
  assign bus.LENGTH         = length_q;
  assign bus.RUNNING        = (state_q == ST_RUN);
  assign bus.DEAD           = (state_q == ST_DEAD);
  assign bus.PIXEL_IS_SNAKE = pix_snake_q;
  assign bus.PIXEL_IS_HEAD  = pix_head_q;

endmodule

// File: tb/tb_snake_body_control.sv
// Self-checking bench for snake_body_control: vector table, scoreboard queue and
// hand-written wrap, growth, collision, reset and pixel-query sequences.
module tb_snake_body_control;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  snake_body_control_if #(.X_WIDTH(8), .Y_WIDTH(7), .LEN_W(6)) bus ();

  snake_body_control dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string name;
    int hx, hy, len, run, dead;
  } exp_t;

  typedef struct {
    string name;
    logic st, tk;
    logic [1:0] dir;
    logic gr;
    int hx, hy, len, run, dead;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs at a falling edge; pulses drop after the next rising edge.
  task automatic drive(input logic st, input logic tk, input logic [1:0] d, input logic gr);
    bus.START     = st;
    bus.MOVE_TICK = tk;
    bus.DIR_IN    = d;
    bus.GROW      = gr;
    @(negedge CLK);
    bus.START     = 1'b0;
    bus.MOVE_TICK = 1'b0;
    bus.GROW      = 1'b0;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: queue empty, expected an entry");
    end else begin
      e = sb_q.pop_front();
      chk({e.name, " HEAD_X"},  int'(bus.HEAD_X),  e.hx);
      chk({e.name, " HEAD_Y"},  int'(bus.HEAD_Y),  e.hy);
      chk({e.name, " LENGTH"},  int'(bus.LENGTH),  e.len);
      chk({e.name, " RUNNING"}, int'(bus.RUNNING), e.run);
      chk({e.name, " DEAD"},    int'(bus.DEAD),    e.dead);
    end
  endtask

  task automatic step_exp(input string nm, input logic st, input logic tk, input logic [1:0] d,
                          input logic gr, input int hx, input int hy, input int len,
                          input int run, input int dead);
    exp_t e;
    e = '{nm, hx, hy, len, run, dead};
    sb_q.push_back(e);
    drive(st, tk, d, gr);
    pop_check();
  endtask

  task automatic pix(input string nm, input int x, input int y, input int es, input int eh);
    bus.PIXEL_X = 8'(x);
    bus.PIXEL_Y = 7'(y);
    @(negedge CLK);
    chk({nm, " IS_SNAKE"}, int'(bus.PIXEL_IS_SNAKE), es);
    chk({nm, " IS_HEAD"},  int'(bus.PIXEL_IS_HEAD),  eh);
  endtask

  task automatic reset_dut();
    RESET = 1'b1;
    drive(1'b0, 1'b0, 2'b11, 1'b0);
    drive(1'b0, 1'b0, 2'b11, 1'b0);
    RESET = 1'b0;
  endtask

  initial begin
    RESET         = 1'b1;
    bus.START     = 1'b0;
    bus.MOVE_TICK = 1'b0;
    bus.DIR_IN    = 2'b11;
    bus.GROW      = 1'b0;
    bus.PIXEL_X   = 8'd80;
    bus.PIXEL_Y   = 7'd60;

    // Reset state (query points at the head, so a stale pixel flop would show)
    sb_q.push_back('{"reset", 80, 60, 4, 0, 0});
    drive(1'b0, 1'b0, 2'b11, 1'b0);
    drive(1'b0, 1'b0, 2'b11, 1'b0);
    pop_check();
    chk("reset IS_SNAKE", int'(bus.PIXEL_IS_SNAKE), 0);
    chk("reset IS_HEAD",  int'(bus.PIXEL_IS_HEAD),  0);
    RESET = 1'b0;

    tbl[0] = '{"start",         1'b1, 1'b0, 2'b11, 1'b0, 80, 60, 4, 1, 0};
    tbl[1] = '{"right1",        1'b0, 1'b1, 2'b11, 1'b0, 81, 60, 4, 1, 0};
    tbl[2] = '{"right2",        1'b0, 1'b1, 2'b11, 1'b0, 82, 60, 4, 1, 0};
    tbl[3] = '{"right3",        1'b0, 1'b1, 2'b11, 1'b0, 83, 60, 4, 1, 0};
    tbl[4] = '{"rev_left",      1'b0, 1'b1, 2'b10, 1'b0, 84, 60, 4, 1, 0};
    tbl[5] = '{"up",            1'b0, 1'b1, 2'b00, 1'b0, 84, 59, 4, 1, 0};
    tbl[6] = '{"dir_no_tick",   1'b0, 1'b0, 2'b01, 1'b0, 84, 59, 4, 1, 0};
    tbl[7] = '{"rev_down",      1'b0, 1'b1, 2'b01, 1'b0, 84, 58, 4, 1, 0};
    tbl[8] = '{"start_in_run",  1'b1, 1'b0, 2'b00, 1'b0, 84, 58, 4, 1, 0};
    tbl[9] = '{"left",          1'b0, 1'b1, 2'b10, 1'b0, 83, 58, 4, 1, 0};
    for (int i = 0; i < 10; i++) begin
      step_exp(tbl[i].name, tbl[i].st, tbl[i].tk, tbl[i].dir, tbl[i].gr,
               tbl[i].hx, tbl[i].hy, tbl[i].len, tbl[i].run, tbl[i].dead);
    end
    // Body is now (83,58),(84,58),(84,59),(84,60)
    pix("q_head", 83, 58, 1, 1);
    pix("q_tail", 84, 60, 1, 0);
    pix("q_miss", 83, 60, 0, 0);

    // Wrap-around on all four edges
    reset_dut();
    drive(1'b1, 1'b0, 2'b11, 1'b0);
    repeat (79) drive(1'b0, 1'b1, 2'b11, 1'b0);
    chk("edge HEAD_X", int'(bus.HEAD_X), 159);
    step_exp("wrap_right", 1'b0, 1'b1, 2'b11, 1'b0, 0, 60, 4, 1, 0);
    repeat (60) drive(1'b0, 1'b1, 2'b00, 1'b0);
    chk("top HEAD_Y", int'(bus.HEAD_Y), 0);
    step_exp("wrap_up",   1'b0, 1'b1, 2'b00, 1'b0, 0,   119, 4, 1, 0);
    step_exp("wrap_left", 1'b0, 1'b1, 2'b10, 1'b0, 159, 119, 4, 1, 0);
    step_exp("wrap_down", 1'b0, 1'b1, 2'b01, 1'b0, 159, 0,   4, 1, 0);

    // Growth: ignored in IDLE, pending across idle cycles, coincident, collapsed, saturated
    reset_dut();
    drive(1'b0, 1'b0, 2'b11, 1'b1);
    step_exp("g_start",   1'b1, 1'b0, 2'b11, 1'b0, 80, 60, 4, 1, 0);
    step_exp("g_idlegrow",1'b0, 1'b1, 2'b11, 1'b0, 81, 60, 4, 1, 0);
    drive(1'b0, 1'b0, 2'b11, 1'b1);
    repeat (5) drive(1'b0, 1'b0, 2'b11, 1'b0);
    step_exp("g_pending", 1'b0, 1'b1, 2'b11, 1'b0, 82, 60, 5, 1, 0);
    pix("g_tail_kept", 78, 60, 1, 0);
    pix("g_past_tail", 77, 60, 0, 0);
    step_exp("g_coinc",   1'b0, 1'b1, 2'b11, 1'b1, 83, 60, 6, 1, 0);
    drive(1'b0, 1'b0, 2'b11, 1'b1);
    drive(1'b0, 1'b0, 2'b11, 1'b1);
    step_exp("g_collapse",1'b0, 1'b1, 2'b11, 1'b0, 84, 60, 7, 1, 0);
    step_exp("g_cleared", 1'b0, 1'b1, 2'b11, 1'b0, 85, 60, 7, 1, 0);
    repeat (25) drive(1'b0, 1'b1, 2'b11, 1'b1);
    chk("g_full LENGTH", int'(bus.LENGTH), 32);
    step_exp("g_saturate",1'b0, 1'b1, 2'b11, 1'b1, 111, 60, 32, 1, 0);
    pix("g_sat_tail", 80, 60, 1, 0);
    pix("g_sat_gone", 79, 60, 0, 0);

    // Self-collision, restart, heading re-init, moving into the vacating tail
    reset_dut();
    drive(1'b1, 1'b0, 2'b11, 1'b0);
    step_exp("c_up",      1'b0, 1'b1, 2'b00, 1'b1, 80, 59, 5, 1, 0);
    step_exp("c_left",    1'b0, 1'b1, 2'b10, 1'b0, 79, 59, 5, 1, 0);
    step_exp("c_hit",     1'b0, 1'b1, 2'b01, 1'b0, 79, 59, 5, 0, 1);
    step_exp("c_deadtick",1'b0, 1'b1, 2'b11, 1'b1, 79, 59, 5, 0, 1);
    step_exp("c_restart", 1'b1, 1'b0, 2'b11, 1'b0, 80, 60, 4, 1, 0);
    step_exp("c_heading", 1'b0, 1'b1, 2'b10, 1'b0, 81, 60, 4, 1, 0);
    step_exp("t_up",      1'b0, 1'b1, 2'b00, 1'b0, 81, 59, 4, 1, 0);
    step_exp("t_left",    1'b0, 1'b1, 2'b10, 1'b0, 80, 59, 4, 1, 0);
    step_exp("t_into_tail",1'b0,1'b1, 2'b01, 1'b0, 80, 60, 4, 1, 0);

    // Growing into the tail cell collides
    reset_dut();
    drive(1'b1, 1'b0, 2'b11, 1'b0);
    step_exp("gc_up",     1'b0, 1'b1, 2'b00, 1'b0, 80, 59, 4, 1, 0);
    step_exp("gc_left",   1'b0, 1'b1, 2'b10, 1'b0, 79, 59, 4, 1, 0);
    step_exp("gc_hit",    1'b0, 1'b1, 2'b01, 1'b1, 79, 59, 4, 0, 1);

    // Reset mid-game coinciding with a move tick
    step_exp("m_restart", 1'b1, 1'b0, 2'b11, 1'b0, 80, 60, 4, 1, 0);
    step_exp("m_tick",    1'b0, 1'b1, 2'b11, 1'b0, 81, 60, 4, 1, 0);
    bus.PIXEL_X = 8'd80;
    bus.PIXEL_Y = 7'd60;
    RESET = 1'b1;
    sb_q.push_back('{"mid_reset", 80, 60, 4, 0, 0});
    drive(1'b0, 1'b1, 2'b11, 1'b1);
    pop_check();
    chk("mid_reset IS_SNAKE", int'(bus.PIXEL_IS_SNAKE), 0);
    RESET = 1'b0;

    // Pixel queries against the freshly initialised body
    pix("p_head",  80, 60, 1, 1);
    pix("p_body",  77, 60, 1, 0);
    pix("p_after", 76, 60, 0, 0);
    pix("p_row",   80, 59, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
